// File: rtl/snn_pkg.sv
// Shared SNN classifier definitions: default count width, classifier FSM
// state encoding and the helper that locates one class count in the
// flattened accumulator bus.
package snn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    SCAN   = 2'd1,
    OUTPUT = 2'd2,
    CLEAR  = 2'd3
  } scc_state_e;

  // LSB position of class idx inside a bus of width-bit counts
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/spike_window_timer.sv
// Timestep window counter. Counts timestep pulses while enabled and flags
// window_done_o combinationally on the pulse that closes the window.
// The owning FSM clears the count through clear_i.
module spike_window_timer #(
  parameter int WINDOW_LEN = 100
) (
  input  logic clk,
  input  logic rstn,
  input  logic timestep_i,
  input  logic en_i,
  input  logic clear_i,
  output logic window_done_o
);

  localparam int            CW   = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign window_done_o = en_i & timestep_i & (cnt_q == LAST);

  // next count: clear wins, otherwise count accepted pulses
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                cnt_d = '0;
    else if (en_i && timestep_i) cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spike_count_classifier.sv
// SNN classifier output stage: waits WINDOW_LEN timesteps, scans the class
// counts one per cycle for the maximum (ties go to the lowest index), offers
// the winner on a valid/ready handshake, then pulses reset_accumulation.
// Optional build macro SCC_TIE_DETECT_EN adds the class_tie output.
module spike_count_classifier
  import snn_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int WINDOW_LEN  = 100,
  parameter int IDX_WIDTH   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              timestep,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] counts,
  output logic                              reset_accumulation,
  output logic                              busy,
  output logic                              class_valid,
  input  logic                              class_ready,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic [DATA_WIDTH-1:0]             class_count
`ifdef SCC_TIE_DETECT_EN
  ,
  output logic                              class_tie
`endif
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  scc_state_e            state_q, state_d;
  logic [IDX_WIDTH-1:0]  scan_idx_q, scan_idx_d;
  logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0] best_q, best_d;
  logic [DATA_WIDTH-1:0] cur;
  logic                  window_done;
`ifdef SCC_TIE_DETECT_EN
  logic                  tie_q, tie_d;
`endif

  spike_window_timer #(.WINDOW_LEN(WINDOW_LEN)) u_timer (
    .clk          (clk),
    .rstn         (rstn),
    .timestep_i   (timestep),
    .en_i         (state_q == ACCUM),
    .clear_i      (window_done),
    .window_done_o(window_done)
  );

  assign cur = counts[slice_lsb(32'(scan_idx_q), DATA_WIDTH) +: DATA_WIDTH];

  assign busy               = (state_q != ACCUM);
  assign class_valid        = (state_q == OUTPUT);
  assign reset_accumulation = (state_q == CLEAR);
  assign class_idx          = best_idx_q;
  assign class_count        = best_q;
`ifdef SCC_TIE_DETECT_EN
  assign class_tie          = tie_q;
`endif

  // next state and argmax scan; best registers hold outside SCAN
  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
`ifdef SCC_TIE_DETECT_EN
    tie_d      = tie_q;
`endif
    unique case (state_q)
      ACCUM: begin
        if (window_done) begin
          state_d    = SCAN;
          scan_idx_d = '0;
        end
      end
      SCAN: begin
        if (scan_idx_q == '0) begin
          best_d     = cur;
          best_idx_d = '0;
`ifdef SCC_TIE_DETECT_EN
          tie_d      = 1'b0;
`endif
        end else if (cur > best_q) begin
          best_d     = cur;
          best_idx_d = scan_idx_q;
`ifdef SCC_TIE_DETECT_EN
          tie_d      = 1'b0;
        end else if (cur == best_q) begin
          tie_d      = 1'b1;
`endif
        end
        if (scan_idx_q == LAST_IDX) begin
          state_d    = OUTPUT;
          scan_idx_d = '0;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      OUTPUT:  if (class_ready) state_d = CLEAR;
      CLEAR:   state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // state and scan registers; reset aborts any scan or pending result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ACCUM;
      scan_idx_q <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
`ifdef SCC_TIE_DETECT_EN
      tie_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
`ifdef SCC_TIE_DETECT_EN
      tie_q      <= tie_d;
`endif
    end
  end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Scoreboard bench for spike_count_classifier (WINDOW_LEN=4, 10 classes).
// Stimulus pushes the hand-computed winner per window; a negedge monitor
// pops and compares on each handshake and also checks result latency and
// the reset_accumulation pulse after every handshake.
module tb_spike_count_classifier;
  localparam int NC = 10;
  localparam int DW = 16;
  localparam int WL = 4;
  localparam int IW = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 timestep = 1'b0;
  logic                 class_ready = 1'b0;
  logic [NC*DW-1:0]     counts = '0;
  logic                 reset_accumulation, busy, class_valid;
  logic [IW-1:0]        class_idx;
  logic [DW-1:0]        class_count;
`ifdef SCC_TIE_DETECT_EN
  logic                 class_tie;
`endif

  typedef struct {
    int unsigned idx;
    int unsigned cnt;
    bit          tie;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t_last = 0;
  int   arm_n = 0;
  int   lat_n = 0;
  bit   prev_valid = 0;
  bit   rac_exp = 0;

  spike_count_classifier #(
    .NUM_CLASSES(NC), .DATA_WIDTH(DW), .WINDOW_LEN(WL)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .timestep          (timestep),
    .counts            (counts),
    .reset_accumulation(reset_accumulation),
    .busy              (busy),
    .class_valid       (class_valid),
    .class_ready       (class_ready),
    .class_idx         (class_idx),
    .class_count       (class_count)
`ifdef SCC_TIE_DETECT_EN
    ,
    .class_tie         (class_tie)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: scoreboard pop on handshake, latency, clear pulse
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (reset_accumulation || rac_exp) chk("reset_acc_pulse", 32'(reset_accumulation), 32'(rac_exp));
      rac_exp = 0;
      if (class_valid && !prev_valid && (arm_n > lat_n)) begin
        chk("latency", 32'(cyc - t_last), 32'(NC + 1));
        lat_n++;
      end
      if (class_valid && class_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("class_idx", 32'(class_idx), e.idx);
          chk("class_count", 32'(class_count), e.cnt);
`ifdef SCC_TIE_DETECT_EN
          chk("class_tie", 32'(class_tie), 32'(e.tie));
`endif
        end
        rac_exp = 1;
      end
    end else begin
      rac_exp = 0;
    end
    prev_valid = class_valid;
  end

  task automatic set_counts(input int c[NC]);
    for (int i = 0; i < NC; i++) counts[i*DW +: DW] = DW'(c[i]);
  endtask

  task automatic pulse();
    @(posedge clk); #1;
    timestep = 1'b1;
    t_last = cyc;
    @(posedge clk); #1;
    timestep = 1'b0;
  endtask

  task automatic expect_result(input int unsigned ei, input int unsigned ec, input bit et);
    exp_t e;
    e.idx = ei; e.cnt = ec; e.tie = et;
    sb.push_back(e);
    arm_n++;
  endtask

  task automatic window(input int c[NC], input int unsigned ei, input int unsigned ec, input bit et);
    set_counts(c);
    repeat (WL) pulse();
    expect_result(ei, ec, et);
  endtask

  task automatic drain();
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c[NC];
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(class_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_racc", 32'(reset_accumulation), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    chk("rst_count", 32'(class_count), 32'd0);
    rstn = 1'b1;
    class_ready = 1'b1;

    // basic winner
    window('{3, 9, 2, 0, 0, 0, 0, 0, 0, 0}, 1, 9, 0);
    drain();

    // tie between classes 2 and 7 resolves low
    for (int i = 0; i < NC; i++) c[i] = i * 3;
    c[2] = 50; c[7] = 50;
    window(c, 2, 50, 1);
    drain();

    // backpressure with timesteps during OUTPUT and CLEAR
    class_ready = 1'b0;
    window('{10, 20, 30, 40, 50, 60, 70, 80, 90, 5}, 8, 90, 0);
    for (int k = 0; k < 40 && !class_valid; k++) @(negedge clk);
    chk("bp_valid_seen", 32'(class_valid), 32'd1);
    @(posedge clk); #1;
    timestep = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("bp_hold_valid", 32'(class_valid), 32'd1);
    chk("bp_hold_idx", 32'(class_idx), 32'd8);
    chk("bp_hold_count", 32'(class_count), 32'd90);
    class_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    timestep = 1'b0;
    drain();
    repeat (WL - 1) pulse();
    repeat (15) @(posedge clk);
    #1;
    chk("bp_counter_idle_valid", 32'(class_valid), 32'd0);
    chk("bp_counter_idle_busy", 32'(busy), 32'd0);
    pulse();
    expect_result(8, 90, 0);
    drain();

    // all zero counts
    window('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 1);
    drain();

    // reset in the middle of the scan (scan index 5)
    set_counts('{1, 2, 3, 700, 4, 5, 6, 7, 8, 9});
    repeat (WL) pulse();
    while (cyc < t_last + 6) begin @(posedge clk); #1; end
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_idx_before", 32'(class_idx), 32'd3);
    rstn = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(class_valid), 32'd0);
    chk("abort_idx", 32'(class_idx), 32'd0);
    chk("abort_count", 32'(class_count), 32'd0);
    chk("abort_racc", 32'(reset_accumulation), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < NC; i++) c[i] = i;
    c[4] = 1000;
    window(c, 4, 1000, 0);
    drain();

    // full-width compare, max at the last class
    for (int i = 0; i < NC; i++) c[i] = 'hFFFE;
    c[9] = 'hFFFF;
    window(c, 9, 'hFFFF, 0);
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
